// File: rtl/morty_wb_ram.sv
// Classic Wishbone single-port RAM responder, 2^ADDR_WIDTH x 32 bits.
// One transfer at a time, WAIT_STATES extra cycles before each ack/err.
// Optional macro MORTY_WBRAM_RANGE_ERR_EN: addresses with upper bits set
// (above ADDR_WIDTH+2) terminate with wb_err_o instead of wrapping.
`timescale 1ns / 1ps
module morty_wb_ram #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [3:0] CntInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [31:0]           dat_q;
  logic [3:0]            sel_q;
  logic                  we_q;
  logic                  rerr_q;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  req;
  logic                  live_rerr;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           acc_dat;
  logic [3:0]            acc_sel;
  logic                  acc_we;
  logic                  acc_rerr;
  logic                  acc_err;
  logic                  access;
  logic                  mem_we;

  assign req = wb_cyc_i & wb_stb_i;

  // Byte-offset bits never matter; upper bits only matter with the range check.
  logic unused_adr;
`ifdef MORTY_WBRAM_RANGE_ERR_EN
  assign live_rerr  = (wb_adr_i >> (ADDR_WIDTH + 2)) != 32'h0;
  assign unused_adr = ^wb_adr_i[1:0];
`else
  assign live_rerr  = 1'b0;
  assign unused_adr = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};
`endif

  // Access fields: live bus in IDLE (zero-wait case), latched copy otherwise
  always_comb begin
    acc_idx  = idx_q;
    acc_dat  = dat_q;
    acc_sel  = sel_q;
    acc_we   = we_q;
    acc_rerr = rerr_q;
    if (state_q == StIdle) begin
      acc_idx  = wb_adr_i[ADDR_WIDTH+1:2];
      acc_dat  = wb_dat_i;
      acc_sel  = wb_sel_i;
      acc_we   = wb_we_i;
      acc_rerr = live_rerr;
    end
    access = 1'b0;
    case (state_q)
      StIdle:  access = req && (WAIT_STATES == 0);
      StWait:  access = req && (cnt_q == 4'd0);
      default: access = 1'b0;
    endcase
    acc_err = (acc_sel == 4'h0) | acc_rerr;
    mem_we  = access & acc_we & ~acc_err;
  end

  // Byte-lane write; no reset so contents survive rst_ni
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_sel[b]) mem[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
      end
    end
  end

  // Control FSM with registered ack/err/read data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      dat_q    <= 32'h0;
      sel_q    <= 4'h0;
      we_q     <= 1'b0;
      rerr_q   <= 1'b0;
      wb_dat_o <= 32'h0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      if (access) begin
        state_q <= StResp;
        if (acc_err) begin
          wb_err_o <= 1'b1;
        end else begin
          wb_ack_o <= 1'b1;
          if (!acc_we) wb_dat_o <= mem[acc_idx];
        end
      end else begin
        case (state_q)
          StIdle: begin
            if (req) begin
              idx_q   <= wb_adr_i[ADDR_WIDTH+1:2];
              dat_q   <= wb_dat_i;
              sel_q   <= wb_sel_i;
              we_q    <= wb_we_i;
              rerr_q  <= live_rerr;
              cnt_q   <= CntInit;
              state_q <= StWait;
            end
          end
          StWait: begin
            // Initiator gave up: drop the transfer silently
            if (!req) begin
              state_q <= StIdle;
              cnt_q   <= 4'd0;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morty_wb_ram.sv
// Scoreboard bench for morty_wb_ram: three instances (WAIT_STATES 1, 0, 3).
`timescale 1ns / 1ps
module tb_morty_wb_ram;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] adr [NI];
  logic [31:0] wdat [NI];
  logic [31:0] rdat [NI];
  logic [3:0]  sel [NI];
  logic        cyc [NI];
  logic        stb [NI];
  logic        we [NI];
  logic        ack [NI];
  logic        err [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    morty_wb_ram #(
      .ADDR_WIDTH (10),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .wb_adr_i(adr[g]),
      .wb_dat_i(wdat[g]),
      .wb_sel_i(sel[g]),
      .wb_cyc_i(cyc[g]),
      .wb_stb_i(stb[g]),
      .wb_we_i (we[g]),
      .wb_dat_o(rdat[g]),
      .wb_ack_o(ack[g]),
      .wb_err_o(err[g])
    );
  end

  function automatic int ws_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  typedef struct {
    int          inst;
    bit          is_err;
    logic [31:0] dat;
    longint      cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  longint      cyc_cnt = 0;
  logic [31:0] last_rd [NI];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: every ack/err must match the head of the scoreboard
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc_cnt) begin
      checks++;
      errors++;
      $display("FAIL missing_resp inst=%0d: no ack/err by cycle %0d, required at cycle %0d",
               sb[0].inst, cyc_cnt, sb[0].cyc);
      void'(sb.pop_front());
    end
    for (int i = 0; i < NI; i++) begin
      if (ack[i] || err[i]) begin
        checks++;
        if (sb.size() == 0 || sb[0].inst != i) begin
          errors++;
          $display("FAIL spurious_resp inst=%0d: ack=%0b err=%0b at cycle %0d, required none",
                   i, ack[i], err[i], cyc_cnt);
        end else begin
          mon_e = sb.pop_front();
          if ({ack[i], err[i]} !== {~mon_e.is_err, mon_e.is_err} || rdat[i] !== mon_e.dat ||
              cyc_cnt != mon_e.cyc) begin
            errors++;
            $display("FAIL resp inst=%0d: ack=%0b err=%0b dat=%h cycle=%0d, required err=%0b dat=%h cycle=%0d",
                     i, ack[i], err[i], rdat[i], cyc_cnt, mon_e.is_err, mon_e.dat, mon_e.cyc);
          end
        end
      end
    end
  end

  // Issue one transfer and queue its expected termination; leaves stb high
  task automatic xfer(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit exp_err, input logic [31:0] exp_rd);
    exp_t e;
    cyc[i]  = 1'b1;
    stb[i]  = 1'b1;
    we[i]   = w;
    adr[i]  = a;
    wdat[i] = d;
    sel[i]  = s;
    if (!w && !exp_err) last_rd[i] = exp_rd;
    e.inst   = i;
    e.is_err = exp_err;
    e.dat    = last_rd[i];
    e.cyc    = cyc_cnt + 1 + ws_of(i);
    sb.push_back(e);
    repeat (ws_of(i) + 2) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    xfer(i, 1'b1, a, d, s, 1'b0, 32'h0);
  endtask

  task automatic rd(input int i, input logic [31:0] a, input logic [31:0] x);
    xfer(i, 1'b0, a, 32'h0, 4'hF, 1'b0, x);
  endtask

  task automatic idle(input int i);
    cyc[i] = 1'b0;
    stb[i] = 1'b0;
    we[i]  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      adr[i] = 32'h0; wdat[i] = 32'h0; sel[i] = 4'h0;
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      last_rd[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_out%0d", i), {30'h0, ack[i], err[i]}, 32'h0);
      chk($sformatf("reset_dat%0d", i), rdat[i], 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WAIT_STATES=1: write/readback, byte lanes, sel=0 error
    wr(0, 32'h10, 32'hDEADBEEF, 4'hF);
    rd(0, 32'h10, 32'hDEADBEEF);
    wr(0, 32'h20, 32'h11223344, 4'hF);
    wr(0, 32'h20, 32'hAABBCCDD, 4'b0100);
    rd(0, 32'h20, 32'h11BB3344);
    rd(0, 32'h23, 32'h11BB3344);
    idle(0);
    xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0);
    idle(0);
    rd(0, 32'h10, 32'hDEADBEEF);
    wr(0, 32'h0, 32'hA5A50F0F, 4'hF);
    wr(0, 32'h4, 32'h2468ACE0, 4'hF);
`ifdef MORTY_WBRAM_RANGE_ERR_EN
    xfer(0, 1'b0, 32'h0001_0000, 32'h0, 4'hF, 1'b1, 32'h0);
    xfer(0, 1'b1, 32'h0001_0004, 32'h13579BDF, 4'hF, 1'b1, 32'h0);
    rd(0, 32'h4, 32'h2468ACE0);
`else
    rd(0, 32'h0001_0000, 32'hA5A50F0F);
    wr(0, 32'h0001_0004, 32'h13579BDF, 4'hF);
    rd(0, 32'h4, 32'h13579BDF);
`endif
    idle(0);

    // WAIT_STATES=0: back-to-back with stb held
    wr(1, 32'h8, 32'h0F0F0F0F, 4'hF);
    wr(1, 32'hC, 32'h77777777, 4'hF);
    idle(1);
    rd(1, 32'h8, 32'h0F0F0F0F);
    rd(1, 32'hC, 32'h77777777);
    idle(1);

    // WAIT_STATES=3: abort by dropping cyc in the second WAIT cycle
    wr(2, 32'h30, 32'h12345678, 4'hF);
    idle(2);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
    adr[2] = 32'h30; wdat[2] = 32'h5; sel[2] = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    cyc[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    stb[2] = 1'b0; we[2] = 1'b0;
    @(posedge clk); #1;
    rd(2, 32'h30, 32'h12345678);
    wr(2, 32'h40, 32'h0BADC0DE, 4'hF);
    idle(2);

    // Reset in the middle of a WAIT on a write
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
    adr[2] = 32'h40; wdat[2] = 32'hCAFEF00D; sel[2] = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    for (int i = 0; i < NI; i++) last_rd[i] = 32'h0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid_ackerr", {30'h0, ack[2], err[2]}, 32'h0);
      chk("rst_mid_dat", rdat[2], 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(2, 32'h40, 32'h0BADC0DE);
    idle(2);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morty_wb_ram.md
MORTY_WB_RAM -- requirements
Module: morty_wb_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, number of word-address bits (memory depth 2^ADDR_WIDTH x 32).
REQ-002 SHALL have parameter WAIT_STATES, default 1, number of extra cycles inserted before each response (0..15).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port wb_adr_i, input, 32, byte address from the initiator.
REQ-006 SHALL have port wb_dat_i, input, 32, write data.
REQ-007 SHALL have port wb_sel_i, input, 4, byte-lane enables; bit n selects bits 8n+7:8n.
REQ-008 SHALL have ports wb_cyc_i, wb_stb_i and wb_we_i, each input, 1: the bus cycle, the strobe and write-enable.
REQ-009 SHALL have port wb_dat_o, output, 32, read data.
REQ-010 SHALL have ports wb_ack_o and wb_err_o, each output, 1: normal and error termination.

Function
REQ-011 SHALL implement a classic Wishbone responder for the initiator's data and instruction ports; one transfer at a time, no pipelining.
REQ-012 SHALL use FSM states IDLE, WAIT and RESP.
REQ-013 SHALL accept a request only in IDLE, when wb_cyc_i & wb_stb_i are sampled high.
  - On acceptance it SHALL latch address, data, sel and we.
REQ-014 On acceptance with WAIT_STATES=0 the FSM SHALL go to RESP. Otherwise it SHALL go to WAIT with the counter set to WAIT_STATES-1.
REQ-015 In WAIT the counter SHALL decrement each cycle. At 0 the FSM SHALL go to RESP.
REQ-016 The memory access SHALL occur on the edge entering RESP. wb_ack_o or wb_err_o SHALL be high for exactly one cycle, the RESP cycle.
  - Latency: acceptance edge to first response cycle = WAIT_STATES+1 cycles.
REQ-017 RESP SHALL return unconditionally to IDLE, so back-to-back requests are separated by at least one IDLE cycle.
REQ-018 The word index SHALL be wb_adr_i[ADDR_WIDTH+1:2]; bits 1:0 SHALL be ignored.
REQ-019 A write SHALL update only the byte lanes whose wb_sel_i bit is 1; the other lanes SHALL be unchanged.
REQ-020 A read SHALL return the full 32-bit word on wb_dat_o during RESP, regardless of sel; lane extraction is the initiator's job.
REQ-021 wb_dat_o SHALL hold its last read value outside RESP; writes SHALL NOT change it.
REQ-022 wb_sel_i == 4'h0 at acceptance SHALL produce wb_err_o instead of wb_ack_o, with no memory write.
REQ-023 If wb_cyc_i or wb_stb_i drops during WAIT, the FSM SHALL abort to IDLE with no access and no ack or err.
REQ-024 wb_ack_o and wb_err_o SHALL never be high in the same cycle.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-026 While rst_ni is low, outputs SHALL be: wb_ack_o=0, wb_err_o=0, wb_dat_o=32'h0, FSM=IDLE, counter=0.
REQ-027 Assertion mid-transfer SHALL discard any pending write without modifying memory, and no response SHALL be issued.
REQ-028 After deassertion, the first request SHALL be accepted no earlier than the first rising edge with rst_ni high.

Configuration
REQ-029 Macro MORTY_WBRAM_RANGE_ERR_EN SHALL control the out-of-range check.
  - Defined: an access with any of wb_adr_i[31:ADDR_WIDTH+2] nonzero SHALL terminate with wb_err_o, no write, and wb_dat_o unchanged.
  - Undefined: upper address bits SHALL be ignored, so the address wraps modulo 2^(ADDR_WIDTH+2) and terminates with wb_ack_o.

Verification
REQ-030 Write and readback, WAIT_STATES=1: write 32'hDEADBEEF to 0x10 with sel=4'hF, then read 0x10 -> ack 2 cycles after each acceptance edge; read data = 32'hDEADBEEF.
REQ-031 Byte lanes: preload 0x20 with 32'h11223344, write 32'hAABBCCDD with sel=4'b0100, then read -> 32'h11BB3344.
REQ-032 Zero-wait and back-to-back, WAIT_STATES=0: two reads with stb held -> ack in the cycle after acceptance, one IDLE cycle between the acks, never two consecutive ack cycles.
REQ-033 Abort: with WAIT_STATES=3, drop cyc in the second WAIT cycle on a write of 32'h5 to 0x30 -> no ack or err; a following read of 0x30 returns the prior value.
REQ-034 Errors: sel=4'h0 write -> single-cycle err, memory unchanged. With MORTY_WBRAM_RANGE_ERR_EN, read 0x0001_0000 (ADDR_WIDTH=10) -> err; without it, same read -> ack with contents of word 0.
REQ-035 Reset mid-WAIT on a write of 32'hCAFEF00D to 0x40 -> ack and err stay 0 and wb_dat_o = 0; after release, read 0x40 returns the prior value.
